// File: rtl/tinytone_pkg.sv
// Shared definitions for the tinytone audio path: envelope state encoding,
// default amplitude resolution and default envelope shaping constants.
package tinytone_pkg;

    // Default amplitude / level resolution in bits.
    localparam int unsigned AMP_BW_DEF = 8;

    // Default envelope timing and shape (12 MHz system clock assumed).
    localparam logic [23:0] TICK_DIV_DEF     = 24'd30000;
    localparam logic [7:0]  ATTACK_STEP_DEF  = 8'd16;
    localparam logic [7:0]  DECAY_STEP_DEF   = 8'd4;
    localparam logic [7:0]  SUSTAIN_LVL_DEF  = 8'd160;
    localparam logic [7:0]  RELEASE_STEP_DEF = 8'd8;

    // Envelope phases; encoding is fixed so other blocks can decode it.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/amp_pwm.sv
// Amplitude PWM gate: a free-running counter compared against the envelope
// level chops the incoming tone, giving an average loudness of level/2^AMP_BW.
module amp_pwm
    import tinytone_pkg::*;
#(
    parameter int unsigned AMP_BW = AMP_BW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tone_i,
    input  logic [AMP_BW-1:0] level_i,
    output logic              pwm_o
);

    logic [AMP_BW-1:0] amp_cnt;
    logic              gate;

    // Free-running amplitude counter, wraps naturally at 2^AMP_BW.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            amp_cnt <= '0;
        end else begin
            amp_cnt <= amp_cnt + 1'b1;
        end
    end

    // Duty comparator: level 0 never opens the gate, full scale opens it
    // for all but one count.
    always_comb begin
        gate = tone_i & (amp_cnt < level_i);
    end

    // Registered output so the pin sees a glitch-free signal.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= gate;
        end
    end

endmodule

// File: rtl/tone_envelope.sv
// ADSR loudness envelope between the tone generator and the audio pin.
// A slow tick paces the level ramps; the level then gates the tone through
// a fast amplitude PWM.
module tone_envelope
    import tinytone_pkg::*;
#(
    parameter int unsigned        AMP_BW       = AMP_BW_DEF,
    parameter logic [23:0]        TICK_DIV     = TICK_DIV_DEF,
    parameter logic [AMP_BW-1:0]  ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter logic [AMP_BW-1:0]  DECAY_STEP   = DECAY_STEP_DEF,
    parameter logic [AMP_BW-1:0]  SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
    parameter logic [AMP_BW-1:0]  RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tone_i,
    input  logic              note_on_i,
    input  logic              note_off_i,
    output logic              pwm_o,
    output logic [AMP_BW-1:0] level_o,
    output logic              busy_o
);

    localparam logic [AMP_BW-1:0] LVL_MAX  = '1;
    localparam logic [23:0]       TICK_TOP = TICK_DIV - 24'd1;

    env_state_e        state;
    env_state_e        state_next;
    logic [AMP_BW-1:0] level;
    logic [AMP_BW-1:0] level_next;
    logic [23:0]       tick_cnt;
    logic              tick;

    logic [AMP_BW:0]   attack_sum;
    logic [AMP_BW-1:0] attack_lvl;
    logic [AMP_BW-1:0] decay_diff;
    logic [AMP_BW-1:0] decay_lvl;
    logic [AMP_BW-1:0] release_lvl;

    // Tick prescaler; a note_on restarts the phase so the first level
    // update lands exactly TICK_DIV cycles after the strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_cnt <= '0;
        end else if (note_on_i) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_TOP) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 24'd1;
        end
    end

    // Ticks only matter while a note is sounding.
    always_comb begin
        tick = (tick_cnt == TICK_TOP) && (state != IDLE);
    end

    // Saturating level arithmetic for each ramping phase.
    always_comb begin
        attack_sum  = {1'b0, level} + {1'b0, ATTACK_STEP};
        attack_lvl  = attack_sum[AMP_BW] ? LVL_MAX : attack_sum[AMP_BW-1:0];
        decay_diff  = (level >= DECAY_STEP) ? (level - DECAY_STEP) : '0;
        decay_lvl   = (decay_diff > SUSTAIN_LVL) ? decay_diff : SUSTAIN_LVL;
        release_lvl = (level >= RELEASE_STEP) ? (level - RELEASE_STEP) : '0;
    end

    // State and level registers; reset aborts a note without any release.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    // Next-state and next-level: note_on beats note_off, and both strobes
    // suppress a level update that would coincide with them.
    always_comb begin
        state_next = state;
        level_next = level;
        if (note_on_i) begin
            state_next = ATTACK;
        end else if (note_off_i &&
                     (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else if (tick) begin
            case (state)
                ATTACK: begin
                    level_next = attack_lvl;
                    if (attack_lvl == LVL_MAX) begin
                        state_next = DECAY;
                    end
                end
                DECAY: begin
                    level_next = decay_lvl;
                    if (decay_lvl == SUSTAIN_LVL) begin
                        state_next = SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    level_next = level;
                end
                RELEASE: begin
                    level_next = release_lvl;
                    if (release_lvl == '0) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded straight from the registers.
    always_comb begin
        busy_o  = (state != IDLE);
        level_o = level;
    end

    amp_pwm #(
        .AMP_BW (AMP_BW)
    ) u_amp_pwm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tone_i  (tone_i),
        .level_i (level),
        .pwm_o   (pwm_o)
    );

endmodule

// File: tb/tb_tone_envelope.sv
// Directed bench for tone_envelope using a short tick period and coarse
// steps so every envelope value can be written down by hand.
module tb_tone_envelope;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone;
    logic       note_on;
    logic       note_off;
    logic       pwm;
    logic [7:0] level;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tone_envelope #(
        .AMP_BW       (8),
        .TICK_DIV     (24'd4),
        .ATTACK_STEP  (8'd64),
        .DECAY_STEP   (8'd16),
        .SUSTAIN_LVL  (8'd128),
        .RELEASE_STEP (8'd32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tone_i     (tone),
        .note_on_i  (note_on),
        .note_off_i (note_off),
        .pwm_o      (pwm),
        .level_o    (level),
        .busy_o     (busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_on(input logic with_off);
        note_on  = 1'b1;
        note_off = with_off;
        step();
        note_on  = 1'b0;
        note_off = 1'b0;
        cyc      = 0;
    endtask

    task automatic pulse_off();
        note_off = 1'b1;
        step();
        note_off = 1'b0;
    endtask

    // Advance to the next tick edge (every 4th edge after the last note_on).
    task automatic next_tick();
        step();
        while (cyc % 4 != 0) step();
    endtask

    task automatic duty(input string tag, input int exp);
        int hi;
        hi = 0;
        repeat (256) begin
            step();
            hi += int'(pwm);
        end
        check_eq(tag, hi, exp);
    endtask

    initial begin
        int e;
        rst_n    = 1'b0;
        tone     = 1'b1;
        note_on  = 1'b0;
        note_off = 1'b0;
        step();
        step();
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_pwm", int'(pwm), 0);
        rst_n = 1'b1;
        step();

        // Full ADSR cycle
        pulse_on(1'b0);
        check_eq("adsr_busy", int'(busy), 1);
        check_eq("adsr_lvl0", int'(level), 0);
        repeat (3) step();
        check_eq("adsr_pretick", int'(level), 0);
        step();
        check_eq("adsr_t1", int'(level), 64);
        next_tick();
        check_eq("adsr_t2", int'(level), 128);
        next_tick();
        check_eq("adsr_t3", int'(level), 192);
        next_tick();
        check_eq("adsr_t4_sat", int'(level), 255);
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            e = 255 - 16 * k;
            if (e < 128) e = 128;
            check_eq($sformatf("adsr_decay%0d", k), int'(level), e);
        end
        repeat (100) step();
        check_eq("sus_hold", int'(level), 128);
        check_eq("sus_busy", int'(busy), 1);
        duty("duty_128", 128);
        tone = 1'b0;
        step();
        duty("duty_tone0", 0);
        tone = 1'b1;
        check_eq("sus_hold2", int'(level), 128);
        pulse_off();
        check_eq("off_nochange", int'(level), 128);
        next_tick();
        check_eq("rel_96", int'(level), 96);
        next_tick();
        check_eq("rel_64", int'(level), 64);
        next_tick();
        check_eq("rel_32", int'(level), 32);
        next_tick();
        check_eq("rel_0", int'(level), 0);
        check_eq("rel_idle", int'(busy), 0);
        step();
        step();
        duty("duty_lvl0", 0);
        pulse_off();
        check_eq("idle_off_ign", int'(busy), 0);

        // Early release from ATTACK
        pulse_on(1'b0);
        next_tick();
        check_eq("early_64", int'(level), 64);
        next_tick();
        check_eq("early_128", int'(level), 128);
        step();
        step();
        pulse_off();
        check_eq("early_off", int'(level), 128);
        check_eq("early_busy", int'(busy), 1);
        next_tick();
        check_eq("early_96", int'(level), 96);
        next_tick();
        check_eq("early_64b", int'(level), 64);
        next_tick();
        check_eq("early_32", int'(level), 32);
        next_tick();
        check_eq("early_0", int'(level), 0);
        check_eq("early_idle", int'(busy), 0);

        // Retrigger during RELEASE at level 64
        pulse_on(1'b0);
        next_tick();
        next_tick();
        check_eq("retr_128", int'(level), 128);
        pulse_off();
        next_tick();
        check_eq("retr_rel96", int'(level), 96);
        next_tick();
        check_eq("retr_rel64", int'(level), 64);
        step();
        pulse_on(1'b0);
        check_eq("retr_keep", int'(level), 64);
        check_eq("retr_busy", int'(busy), 1);
        repeat (3) step();
        check_eq("retr_phase", int'(level), 64);
        step();
        check_eq("retr_128b", int'(level), 128);
        next_tick();
        check_eq("retr_192", int'(level), 192);
        next_tick();
        check_eq("retr_255", int'(level), 255);
        repeat (8) next_tick();
        check_eq("retr_sus", int'(level), 128);

        // note_on and note_off together in SUSTAIN
        pulse_on(1'b1);
        check_eq("both_busy", int'(busy), 1);
        check_eq("both_keep", int'(level), 128);
        next_tick();
        check_eq("both_192", int'(level), 192);
        next_tick();
        check_eq("both_255", int'(level), 255);
        next_tick();
        check_eq("both_decay", int'(level), 239);

        // Reset in the middle of a note
        rst_n = 1'b0;
        step();
        step();
        check_eq("mrst_level", int'(level), 0);
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_pwm", int'(pwm), 0);
        rst_n = 1'b1;
        step();
        check_eq("mrst_level2", int'(level), 0);
        check_eq("mrst_busy2", int'(busy), 0);
        check_eq("mrst_pwm2", int'(pwm), 0);
        repeat (8) step();
        check_eq("mrst_stay", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tone_envelope.md
Name: tone_envelope

Overview:
Amplitude-envelope stage between the tone PWM generator and the audio output pin.
- Consumes the 1-bit square-wave tone and the per-note strobe.
- Applies an attack/decay/sustain/release (ADSR) loudness envelope by gating the tone with a second, faster amplitude PWM.
- Drives the final 1-bit sound output.
- Removes clicks and makes successive sequence notes audibly distinct.

Parameters:
AMP_BW, 8, amplitude/level resolution in bits
TICK_DIV, 24'd30000, clk cycles per envelope tick (~2.5 ms at 12 MHz)
ATTACK_STEP, 8'd16, level increment per tick in ATTACK
DECAY_STEP, 8'd4, level decrement per tick in DECAY
SUSTAIN_LVL, 8'd160, level held in SUSTAIN
RELEASE_STEP, 8'd8, level decrement per tick in RELEASE

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
tone_i  in  1  square-wave tone from PWM generator
note_on_i  in  1  single-cycle pulse, starts/retriggers envelope
note_off_i  in  1  single-cycle pulse, enters release
pwm_o  out  1  enveloped tone, registered
level_o  out  AMP_BW  current envelope level
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at a rising edge) sets:
  - state=IDLE, level=0, tick_cnt=0, amp_cnt=0.
  - pwm_o=0, busy_o=0.
  - Reset mid-note aborts immediately; no release phase.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Tick counter:
  - Increments every cycle and wraps at TICK_DIV-1.
  - Cleared to 0 in the cycle note_on_i is sampled.
  - tick = (tick_cnt==TICK_DIV-1) && state!=IDLE.
  - First tick after note_on therefore occurs exactly TICK_DIV cycles later.
- note_on_i = 1, any state:
  - Next state ATTACK.
  - Level is NOT cleared; retrigger ramps from the current level.
- note_off_i = 1:
  - In ATTACK, DECAY or SUSTAIN: next state RELEASE; level unchanged that cycle.
  - In IDLE or RELEASE: ignored.
- Simultaneous note_on_i and note_off_i: note_on wins.
- Level updates occur only on tick cycles. All arithmetic saturates; no wrap.
  - ATTACK: level = min(level+ATTACK_STEP, 2^AMP_BW-1). If the result is the max, go to DECAY.
  - DECAY: level = max(level-DECAY_STEP, SUSTAIN_LVL). If the result equals SUSTAIN_LVL, go to SUSTAIN. If level is already <= SUSTAIN_LVL on entry, the first tick sets SUSTAIN_LVL and goes to SUSTAIN.
  - SUSTAIN: level held indefinitely. This includes SUSTAIN_LVL=0; busy_o stays 1.
  - RELEASE: level = max(level-RELEASE_STEP, 0). If the result is 0, go to IDLE.
- Amplitude PWM:
  - amp_cnt is a free-running AMP_BW-bit counter that wraps.
  - pwm_o registered as tone_i & (amp_cnt < level). Latency 1 cycle from tone_i/level to pwm_o.
  - level=0 gives pwm_o constant 0.
  - level=255 gives 255/256 duty while tone_i=1.
- Outputs:
  - level_o is the level register, direct.
  - busy_o is combinational from state.

Decomposition:
- Shared package tinytone_pkg holds:
  - State encoding constants: IDLE=3'd0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
  - AMP_BW default.
  - Default step/sustain constants, shared with the top level.
- One sub-module, amp_pwm:
  - Holds the amp_cnt counter, comparator and registered output gate.
  - Ports: clk_i, rst_ni, tone_i, level_i, pwm_o.
  - The FSM, tick counter and level arithmetic stay in tone_envelope.

Test Plan:
All scenarios use bench parameters TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LVL=128, RELEASE_STEP=32, tone_i held 1.
- Reset check: rst_ni=0 for 2 cycles mid-activity -> next cycle level_o=0, busy_o=0, pwm_o=0, state IDLE.
- Full ADSR:
  - Stimulus: note_on pulse at cycle 0.
  - level_o 64,128,192,255 at ticks 1-4 (cycles 4,8,12,16), then DECAY 239…143, 128 at tick 12.
  - SUSTAIN holds 128 for 100 cycles.
  - note_off -> 96,64,32,0 on the next 4 ticks, then busy_o=0.
- Early release: note_off 2 cycles after the level reaches 128 in ATTACK -> RELEASE; 96,64,32,0 over 4 ticks; DECAY never entered.
- Retrigger: note_on during RELEASE at level 64 -> ATTACK from 64; 128,192,255 on subsequent ticks; tick phase restarted, so first update is 4 cycles later.
- Simultaneous pulses: note_on and note_off same cycle in SUSTAIN -> ATTACK; level 192 on the next tick.
- PWM duty:
  - level=128 steady with tone_i=1 -> pwm_o high exactly 128 of every 256 cycles.
  - tone_i=0 -> pwm_o=0 always.
  - level=0 -> pwm_o=0 always.
